icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, word-address width.
REQ-002 SHALL have parameter WORD_W, default 16, data word width.
REQ-003 SHALL have parameter LINE_WORDS, default 4, words per line; power of two, at least 2.
REQ-004 SHALL have parameter NUM_LINES, default 4, direct-mapped lines; power of two, at least 2.
REQ-005 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports cpu_req (in, 1), cpu_addr (in, ADDR_W), cpu_ready (out, 1), cpu_rdata (out, WORD_W): fetch request, word address, one-cycle response strobe, response data.
REQ-008 SHALL have ports mem_req (out, 1), mem_addr (out, ADDR_W), mem_rvalid (in, 1), mem_rdata (in, WORD_W): refill request, refill word address, return strobe, return data.
REQ-009 SHALL have port flush, input, 1, invalidate-all request.

Function
REQ-010 SHALL split the address as offset = low log2(LINE_WORDS) bits, index = next log2(NUM_LINES) bits, tag = remaining upper bits.
REQ-011 SHALL store a valid bit, a tag and LINE_WORDS data words per line.
REQ-012 SHALL implement FSM IDLE, REFILL and RESPOND.
REQ-013 SHALL, in IDLE with cpu_req=1 and flush=0, latch cpu_addr; on hit, stay in IDLE and pulse cpu_ready with the addressed word on the next cycle (1-cycle hit latency).
REQ-014 SHALL, on miss, enter REFILL with word counter 0 and clear the line's valid bit.
REQ-015 SHALL, in REFILL, hold mem_req=1 and drive mem_addr = {latched tag, latched index, counter}, starting at the line base regardless of the requested offset.
REQ-016 SHALL, on each mem_rvalid in REFILL, write mem_rdata to word counter and increment the counter.
REQ-017 SHALL, on the last word (counter = LINE_WORDS-1 with mem_rvalid), write the tag, set valid, drop mem_req the next cycle and enter RESPOND.
REQ-018 SHALL, in RESPOND, pulse cpu_ready for one cycle with the requested word, then return to IDLE.
REQ-019 SHALL hold cpu_req and cpu_addr stable from issue until cpu_ready as a requester obligation; the cache uses only the latched address after acceptance.
REQ-020 SHALL ignore mem_rvalid outside REFILL.
REQ-021 SHALL, on flush in IDLE, clear all valid bits in one cycle; a simultaneous cpu_req is not accepted that cycle and is serviced after as a miss.
REQ-022 SHALL, on flush during REFILL or RESPOND, record it as pending and apply it on the first IDLE cycle, after the in-flight response is delivered.
REQ-023 SHALL drive cpu_rdata=0 whenever cpu_ready=0.

Reset
REQ-024 SHALL, on reset_n low, asynchronously enter IDLE, clear all valid bits, the counter and pending flush, and force cpu_ready=0, cpu_rdata=0, mem_req=0, mem_addr=0.
REQ-025 SHALL, on reset mid-REFILL, abandon the refill with no line left valid and ignore any later mem_rvalid.

Configuration
REQ-026 SHALL, with ICACHE_STATS_EN defined, add outputs hit_cnt and miss_cnt (16 bits each), each reset to 0, incremented once per accepted hit/miss and saturating at 16'hFFFF.
REQ-027 SHALL, without ICACHE_STATS_EN, omit those ports and counters entirely.

Verification
REQ-028 SHALL test a cold miss: read 0x0012 with memory returning 0xA000+addr -> mem_addr 0x0010..0x0013 in order; cpu_ready once with 0xA012.
REQ-029 SHALL test a hit after refill: read 0x0013 -> cpu_ready on the next cycle with 0xA013, mem_req stays 0.
REQ-030 SHALL test a conflict: read 0x0052 after 0x0012 -> refill 0x0050..0x0053; a later 0x0012 misses again.
REQ-031 SHALL test flush during refill: flush pulses at the second return word -> response delivered, then all lines invalid; re-reading 0x0013 misses.
REQ-032 SHALL test reset mid-refill: reset_n low after 2 return words -> mem_req 0 immediately; 0x0010 misses after release.
REQ-033 SHALL test counter saturation with ICACHE_STATS_EN: preload hit_cnt 0xFFFE, run 3 hits -> hit_cnt 0xFFFF.

Source files
------------

// File: rtl/icache_if.sv
// CPU fetch / memory refill / flush signals between the direct-mapped icache and its environment.
interface icache_if #(
   parameter int ADDR_W = 16,
   parameter int WORD_W = 16
);
   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_ready;
   logic [WORD_W-1:0] cpu_rdata;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid;
   logic [WORD_W-1:0] mem_rdata;
   logic              flush;

   modport master (output cpu_req, cpu_addr, mem_rvalid, mem_rdata, flush,
                   input  cpu_ready, cpu_rdata, mem_req, mem_addr);
   modport slave  (input  cpu_req, cpu_addr, mem_rvalid, mem_rdata, flush,
                   output cpu_ready, cpu_rdata, mem_req, mem_addr);
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with line refill from a word-wide memory.
// Define ICACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_dm #(
   parameter int ADDR_W     = 16,
   parameter int WORD_W     = 16,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
`endif
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

   typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_e;

   state_e                   state_q, state_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic [OFF_W-1:0]         cnt_q, cnt_d;
   logic                     pend_q, pend_d;
   logic                     ready_q, ready_d;
   logic [WORD_W-1:0]        rdata_q, rdata_d;
   logic [NUM_LINES-1:0]     valid_q;
   logic [NUM_LINES-1:0][TAG_W-1:0]                   tag_q;
   logic [NUM_LINES-1:0][LINE_WORDS-1:0][WORD_W-1:0]  data_q;
   logic                     flush_all, clr_line, wr_en, set_valid, accept, hit_now;

   logic [OFF_W-1:0] in_off, q_off;
   logic [IDX_W-1:0] in_idx, q_idx;
   logic [TAG_W-1:0] in_tag, q_tag;

   assign in_off = bus.cpu_addr[OFF_W-1:0];
   assign in_idx = bus.cpu_addr[OFF_W +: IDX_W];
   assign in_tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];
   assign q_off  = addr_q[OFF_W-1:0];
   assign q_idx  = addr_q[OFF_W +: IDX_W];
   assign q_tag  = addr_q[ADDR_W-1 -: TAG_W];

   // No new request while a response is on the bus: the requester still holds cpu_req that cycle.
   assign accept  = (state_q == IDLE) && !bus.flush && !pend_q && bus.cpu_req && !ready_q;
   assign hit_now = valid_q[in_idx] && (tag_q[in_idx] == in_tag);

   assign bus.cpu_ready = ready_q;
   assign bus.cpu_rdata = rdata_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      ready_d      = 1'b0;
      rdata_d      = '0;
      flush_all    = 1'b0;
      clr_line     = 1'b0;
      wr_en        = 1'b0;
      set_valid    = 1'b0;
      bus.mem_req  = 1'b0;
      bus.mem_addr = '0;
      case (state_q)
         IDLE: begin
            if (bus.flush || pend_q) begin
               flush_all = 1'b1;
               pend_d    = 1'b0;
            end else if (accept) begin
               addr_d = bus.cpu_addr;
               if (hit_now) begin
                  ready_d = 1'b1;
                  rdata_d = data_q[in_idx][in_off];
               end else begin
                  clr_line = 1'b1;
                  cnt_d    = '0;
                  state_d  = REFILL;
               end
            end
         end
         REFILL: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = {addr_q[ADDR_W-1:OFF_W], cnt_q};
            if (bus.flush) pend_d = 1'b1;
            if (bus.mem_rvalid) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == OFF_W'(LINE_WORDS-1)) begin
                  // The requested word may be the one arriving right now.
                  set_valid = 1'b1;
                  ready_d   = 1'b1;
                  rdata_d   = (q_off == cnt_q) ? bus.mem_rdata : data_q[q_idx][q_off];
                  state_d   = RESPOND;
               end
            end
         end
         RESPOND: begin
            if (bus.flush) pend_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         ready_q <= 1'b0;
         rdata_q <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         if (flush_all)      valid_q        <= '0;
         else if (clr_line)  valid_q[in_idx] <= 1'b0;
         else if (set_valid) valid_q[q_idx]  <= 1'b1;
      end
   end

   // Storage needs no reset; the valid bits guard it.
   always_ff @(posedge clk) begin
      if (wr_en)     data_q[q_idx][cnt_q] <= bus.mem_rdata;
      if (set_valid) tag_q[q_idx]         <= q_tag;
   end

`ifdef ICACHE_STATS_EN
   logic [15:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (accept) begin
         if (hit_now && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
         if (!hit_now && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm; memory returns 0xA000+address one word per cycle.
module tb_icache_dm;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic stray_rv = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [15:0] log_q[$];

   always #5 clk = ~clk;

   icache_if #(.ADDR_W(16), .WORD_W(16)) bus ();

`ifdef ICACHE_STATS_EN
   logic [15:0] hit_cnt, miss_cnt;
   icache_dm dut (.clk(clk), .reset_n(reset_n), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
   icache_dm dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

   // Memory model: answers every refill beat in the same cycle it is requested.
   always @(negedge clk) begin
      bus.mem_rvalid = bus.mem_req || stray_rv;
      bus.mem_rdata  = 16'hA000 + bus.mem_addr;
      if (bus.mem_req) log_q.push_back(bus.mem_addr);
   end

   task automatic do_read(input logic [15:0] a, output logic seen, output logic [15:0] data,
                          output int lat, output logic rdy_after);
      log_q.delete();
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = a;
      seen = 1'b0; data = '0; lat = 0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk); #1;
         if (bus.cpu_ready) begin seen = 1'b1; lat = i; data = bus.cpu_rdata; end
      end
      bus.cpu_req = 1'b0;
      @(negedge clk); #1;
      rdy_after = bus.cpu_ready;
   endtask

   task automatic test_reset;
      checks += 4;
      if (bus.cpu_ready !== 1'b0)    begin errors++; $display("FAIL rst_ready got %b exp 0", bus.cpu_ready); end
      if (bus.cpu_rdata !== 16'h0)   begin errors++; $display("FAIL rst_rdata got %h exp 0000", bus.cpu_rdata); end
      if (bus.mem_req !== 1'b0)      begin errors++; $display("FAIL rst_mem_req got %b exp 0", bus.mem_req); end
      if (bus.mem_addr !== 16'h0)    begin errors++; $display("FAIL rst_mem_addr got %h exp 0000", bus.mem_addr); end
   endtask

   task automatic test_cold_miss;
      logic s, ra; logic [15:0] d; int l;
      do_read(16'h0012, s, d, l, ra);
      checks += 9;
      if (s !== 1'b1)      begin errors++; $display("FAIL cold_ready got %b exp 1", s); end
      if (d !== 16'hA012)  begin errors++; $display("FAIL cold_data got %h exp A012", d); end
      if (l != 5)          begin errors++; $display("FAIL cold_latency got %0d exp 5", l); end
      if (ra !== 1'b0)     begin errors++; $display("FAIL cold_pulse got %b exp 0", ra); end
      if (log_q.size() != 4) begin errors++; $display("FAIL cold_beats got %0d exp 4", log_q.size()); end
      for (int k = 0; k < 4; k++)
         if (log_q[k] !== 16'h0010 + 16'(k)) begin errors++; $display("FAIL cold_addr%0d got %h exp %h", k, log_q[k], 16'h0010 + 16'(k)); end
   endtask

   task automatic test_hit;
      logic s, ra; logic [15:0] d; int l;
      do_read(16'h0013, s, d, l, ra);
      checks += 4;
      if (d !== 16'hA013)    begin errors++; $display("FAIL hit_data got %h exp A013", d); end
      if (l != 1)            begin errors++; $display("FAIL hit_latency got %0d exp 1", l); end
      if (log_q.size() != 0) begin errors++; $display("FAIL hit_mem_req beats got %0d exp 0", log_q.size()); end
      if (ra !== 1'b0)       begin errors++; $display("FAIL hit_pulse got %b exp 0", ra); end
   endtask

   task automatic test_conflict;
      logic s, ra; logic [15:0] d; int l;
      do_read(16'h0052, s, d, l, ra);
      checks += 6;
      if (d !== 16'hA052)    begin errors++; $display("FAIL conf_data got %h exp A052", d); end
      if (log_q.size() != 4) begin errors++; $display("FAIL conf_beats got %0d exp 4", log_q.size()); end
      if (log_q[0] !== 16'h0050) begin errors++; $display("FAIL conf_addr0 got %h exp 0050", log_q[0]); end
      if (log_q[3] !== 16'h0053) begin errors++; $display("FAIL conf_addr3 got %h exp 0053", log_q[3]); end
      do_read(16'h0012, s, d, l, ra);
      if (d !== 16'hA012)    begin errors++; $display("FAIL conf_reread_data got %h exp A012", d); end
      if (log_q.size() != 4) begin errors++; $display("FAIL conf_reread_beats got %0d exp 4", log_q.size()); end
   endtask

   task automatic test_flush_refill;
      logic s, ra, fl_done; logic [15:0] d; int l;
      do_read(16'h0014, s, d, l, ra);  // fill a second line
      checks += 1;
      if (d !== 16'hA014) begin errors++; $display("FAIL fr_prefill_data got %h exp A014", d); end
      log_q.delete();
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0028;
      s = 1'b0; fl_done = 1'b0; d = '0;
      for (int i = 1; i <= 40 && !s; i++) begin
         @(negedge clk); #1;
         if (log_q.size() == 2 && !fl_done) begin bus.flush = 1'b1; fl_done = 1'b1; end
         else bus.flush = 1'b0;
         if (bus.cpu_ready) begin s = 1'b1; d = bus.cpu_rdata; end
      end
      bus.cpu_req = 1'b0; bus.flush = 1'b0;
      @(negedge clk); #1;
      checks += 6;
      if (s !== 1'b1)      begin errors++; $display("FAIL fr_ready got %b exp 1", s); end
      if (d !== 16'hA028)  begin errors++; $display("FAIL fr_data got %h exp A028", d); end
      do_read(16'h0013, s, d, l, ra);
      if (d !== 16'hA013)    begin errors++; $display("FAIL fr_0013_data got %h exp A013", d); end
      if (log_q.size() != 4) begin errors++; $display("FAIL fr_0013_beats got %0d exp 4", log_q.size()); end
      do_read(16'h0014, s, d, l, ra);
      if (log_q.size() != 4) begin errors++; $display("FAIL fr_0014_beats got %0d exp 4", log_q.size()); end
      do_read(16'h0028, s, d, l, ra);
      if (log_q.size() != 4) begin errors++; $display("FAIL fr_0028_beats got %0d exp 4", log_q.size()); end
   endtask

   task automatic test_flush_idle;
      logic s, ra; logic [15:0] d; int l;
      do_read(16'h0013, s, d, l, ra);  // line 0 holds 0x001x, so this hits
      checks += 4;
      if (l != 1) begin errors++; $display("FAIL fi_prehit_latency got %0d exp 1", l); end
      bus.flush = 1'b1; bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0013;
      @(negedge clk); #1;
      bus.flush = 1'b0;
      if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL fi_not_accepted got %b exp 0", bus.cpu_ready); end
      do_read(16'h0013, s, d, l, ra);
      if (d !== 16'hA013)    begin errors++; $display("FAIL fi_data got %h exp A013", d); end
      if (log_q.size() != 4) begin errors++; $display("FAIL fi_beats got %0d exp 4", log_q.size()); end
   endtask

   task automatic test_reset_refill;
      logic s, ra; logic [15:0] d; int l;
      do_read(16'h0010, s, d, l, ra);  // hit before reset
      checks += 10;
      if (l != 1) begin errors++; $display("FAIL rr_prehit_latency got %0d exp 1", l); end
      log_q.delete();
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0034;
      for (int i = 0; i < 40 && log_q.size() < 2; i++) begin @(negedge clk); #1; end
      @(posedge clk); #1;
      reset_n = 1'b0; bus.cpu_req = 1'b0;
      #1;
      if (bus.mem_req !== 1'b0)   begin errors++; $display("FAIL rr_mem_req got %b exp 0", bus.mem_req); end
      if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL rr_mem_addr got %h exp 0000", bus.mem_addr); end
      if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL rr_ready got %b exp 0", bus.cpu_ready); end
      @(negedge clk); #1;
      reset_n = 1'b1;
      stray_rv = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      stray_rv = 1'b0;
      if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL rr_stray_ready got %b exp 0", bus.cpu_ready); end
      if (bus.mem_req !== 1'b0)   begin errors++; $display("FAIL rr_stray_mem_req got %b exp 0", bus.mem_req); end
      @(negedge clk); #1;
      do_read(16'h0010, s, d, l, ra);
      if (d !== 16'hA010)    begin errors++; $display("FAIL rr_0010_data got %h exp A010", d); end
      if (log_q.size() != 4) begin errors++; $display("FAIL rr_0010_beats got %0d exp 4", log_q.size()); end
      do_read(16'h0034, s, d, l, ra);
      if (d !== 16'hA034)    begin errors++; $display("FAIL rr_0034_data got %h exp A034", d); end
      if (log_q.size() != 4) begin errors++; $display("FAIL rr_0034_beats got %0d exp 4", log_q.size()); end
   endtask

`ifdef ICACHE_STATS_EN
   task automatic test_stats_sat;
      logic s, ra; logic [15:0] d; int l;
      force dut.hit_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut.hit_cnt_q;
      #1;
      for (int k = 0; k < 3; k++) do_read(16'h0034, s, d, l, ra);
      checks += 2;
      if (l != 1)              begin errors++; $display("FAIL st_hit_latency got %0d exp 1", l); end
      if (hit_cnt !== 16'hFFFF) begin errors++; $display("FAIL st_hit_cnt got %h exp FFFF", hit_cnt); end
   endtask
`endif

   initial begin
      bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.flush = 1'b0;
      bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      test_reset;
      reset_n = 1'b1;
      @(negedge clk); #1;
      test_reset;
      test_cold_miss;
      test_hit;
      test_conflict;
      test_flush_refill;
      test_flush_idle;
      test_reset_refill;
`ifdef ICACHE_STATS_EN
      test_stats_sat;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
